// File: rtl/regfile_arb_pkg.sv
// Shared widths and the writeback slot record for the regfile write arbiter.
package regfile_arb_pkg;

    localparam int XLEN            = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int NUM_WRITE_PORTS = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-grant picker: scans full slots upward from start (modulo NUM_REQ);
// the second candidate is withheld, not skipped past, when it targets the same register as the first.
module rr_pick2
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]            full,
    input  logic [PTR_W-1:0]              start,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] addrs,
    output logic [NUM_REQ-1:0]            grant1,
    output logic [NUM_REQ-1:0]            grant2
);

    logic [REG_ADDR_W-1:0] slot_addr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign slot_addr[i] = addrs[i*REG_ADDR_W +: REG_ADDR_W];
    end

    always_comb begin
        logic                  found1;
        logic                  found2;
        logic [REG_ADDR_W-1:0] first_addr;
        logic [PTR_W:0]        sum;
        logic [PTR_W-1:0]      idx;
        found1     = 1'b0;
        found2     = 1'b0;
        first_addr = '0;
        sum        = '0;
        idx        = '0;
        grant1     = '0;
        grant2     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, start} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (full[idx]) begin
                if (!found1) begin
                    found1      = 1'b1;
                    first_addr  = slot_addr[idx];
                    grant1[idx] = 1'b1;
                end else if (!found2) begin
                    // Second candidate is consumed even when suppressed, so same-register writes stay ordered.
                    found2 = 1'b1;
                    if (slot_addr[idx] != first_addr) begin
                        grant2[idx] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares two registered regfile write ports among NUM_REQ one-entry writeback slots; accept->port is one cycle,
// a slot is ready when empty or being granted. REGFILE_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             reqValid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0]  reqAddr,
    input  logic [NUM_REQ*XLEN-1:0]        reqData,
    output logic [NUM_REQ-1:0]             reqReady,
    output logic                           writeEnable1,
    output logic                           writeEnable2,
    output logic [REG_ADDR_W-1:0]          addressForWriting1,
    output logic [REG_ADDR_W-1:0]          addressForWriting2,
    output logic [XLEN-1:0]                valueForWriting1,
    output logic [XLEN-1:0]                valueForWriting2,
    output logic [(1<<REG_ADDR_W)-1:0]     pendingMask
);

    localparam int PTR_W = $clog2(NUM_REQ);

    wb_req_t                     slot     [NUM_REQ];
    logic [NUM_REQ-1:0]          full;
    logic [NUM_REQ-1:0]          grant1;
    logic [NUM_REQ-1:0]          grant2;
    logic [NUM_REQ-1:0]          granted;
    logic [NUM_REQ-1:0]          accept;
    logic [NUM_REQ*REG_ADDR_W-1:0] slot_addrs;
    logic [PTR_W-1:0]            start;
    logic [REG_ADDR_W-1:0]       req_addr [NUM_REQ];
    logic [XLEN-1:0]             req_data [NUM_REQ];
    wb_req_t                     port_nxt [NUM_WRITE_PORTS];
    wb_req_t                     port_q   [NUM_WRITE_PORTS];
    logic [NUM_WRITE_PORTS-1:0]  port_en_nxt;
    logic [NUM_WRITE_PORTS-1:0]  port_en_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot_io
        assign req_addr[i] = reqAddr[i*REG_ADDR_W +: REG_ADDR_W];
        assign req_data[i] = reqData[i*XLEN +: XLEN];
        assign slot_addrs[i*REG_ADDR_W +: REG_ADDR_W] = slot[i].addr;
    end

    rr_pick2 #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .full   (full),
        .start  (start),
        .addrs  (slot_addrs),
        .grant1 (grant1),
        .grant2 (grant2)
    );

    assign granted  = grant1 | grant2;
    assign reqReady = {NUM_REQ{reset}} & (~full | granted);
    assign accept   = reqValid & reqReady;

    always_comb begin
        port_nxt[0] = '0;
        port_nxt[1] = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant1[k]) port_nxt[0] = slot[k];
            if (grant2[k]) port_nxt[1] = slot[k];
        end
    end

    assign port_en_nxt = {|grant2, |grant1};

    always_ff @(posedge clock) begin
        if (!reset) begin
            full      <= '0;
            port_en_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot[i] <= '0;
            end
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                port_q[p] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    // x0 writes complete the handshake but never occupy the slot.
                    full[i]      <= (req_addr[i] != '0);
                    slot[i].addr <= req_addr[i];
                    slot[i].data <= req_data[i];
                end else if (granted[i]) begin
                    full[i] <= 1'b0;
                end
            end
            port_en_q <= port_en_nxt;
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                port_q[p] <= port_nxt[p];
            end
        end
    end

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [PTR_W-1:0] rr;
    logic [PTR_W-1:0] last_idx;

    always_comb begin
        last_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant1[k]) last_idx = PTR_W'(k);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant2[k]) last_idx = PTR_W'(k);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr <= '0;
        end else if (|granted) begin
            rr <= (last_idx == PTR_W'(NUM_REQ-1)) ? '0 : last_idx + PTR_W'(1);
        end
    end

    assign start = rr;
`endif

    assign writeEnable1       = port_en_q[0];
    assign writeEnable2       = port_en_q[1];
    assign addressForWriting1 = port_q[0].addr;
    assign addressForWriting2 = port_q[1].addr;
    assign valueForWriting1   = port_q[0].data;
    assign valueForWriting2   = port_q[1].data;

    always_comb begin
        pendingMask = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (full[k]) pendingMask[slot[k].addr] = 1'b1;
        end
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            if (port_en_q[p]) pendingMask[port_q[p].addr] = 1'b1;
        end
        pendingMask[0] = 1'b0;
    end

endmodule
